// File: rtl/state_seq_timer.sv
// rtl/state_seq_timer.sv - per-channel duration sequencer; optional request queueing via STATE_SEQ_TIMER_PEND_EN
module state_seq_timer #(
    parameter int N_CH  = 5,
    parameter int CNT_W = 22,
    parameter int CH_W  = 3
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        start,
    input  logic [N_CH-1:0]        state_over_in,
    input  logic [N_CH*CNT_W-1:0]  datain,
    input  logic                   abort,
    output logic [N_CH-1:0]        clk_en,
    output logic                   busy,
    output logic [CH_W-1:0]        active_ch,
    output logic                   done,
    output logic                   early
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  load_val;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [N_CH-1:0]   clk_en_q, clk_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              early_q, early_d;
    logic [N_CH-1:0]   req;
    logic [CH_W-1:0]   sel_idx;
    logic              req_any;

`ifdef STATE_SEQ_TIMER_PEND_EN
    logic [N_CH-1:0]   pend_q, pend_d;
    logic [N_CH-1:0]   sel_oh;

    assign req    = start | pend_q;
    // Isolate the lowest set bit: the request that wins arbitration.
    assign sel_oh = req & ~(req - N_CH'(1));
`else
    assign req    = start;
`endif

    assign req_any = |req;

    always_comb begin
        sel_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) sel_idx = CH_W'(i);
        end
    end

    always_comb begin
        load_val = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_q == CH_W'(i)) load_val = datain[i*CNT_W +: CNT_W];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        early_d = 1'b0;
`ifdef STATE_SEQ_TIMER_PEND_EN
        pend_d  = (state_q != S_IDLE) ? (pend_q | start) : pend_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    state_d = S_LOAD;
                    ch_d    = sel_idx;
`ifdef STATE_SEQ_TIMER_PEND_EN
                    pend_d  = req & ~sel_oh;
`endif
                end
            end
            S_LOAD: begin
                cnt_d   = load_val;
                state_d = (load_val != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                // Early termination outranks a simultaneous time-up.
                if (state_over_in[ch_q]) begin
                    state_d = S_DONE;
                    early_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef STATE_SEQ_TIMER_PEND_EN
                if (req_any) begin
                    state_d = S_LOAD;
                    ch_d    = sel_idx;
                    pend_d  = req & ~sel_oh;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            early_d = 1'b0;
`ifdef STATE_SEQ_TIMER_PEND_EN
            pend_d  = '0;
`endif
        end
    end

    // Outputs are derived from the next state so they line up with it once registered.
    always_comb begin
        clk_en_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            clk_en_d[i] = (state_d == S_RUN) && (ch_d == CH_W'(i));
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ch_q     <= '0;
            clk_en_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            early_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            clk_en_q <= clk_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            early_q  <= early_d;
        end
    end

`ifdef STATE_SEQ_TIMER_PEND_EN
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end
`endif

    assign clk_en    = clk_en_q;
    assign busy      = busy_q;
    assign active_ch = ch_q;
    assign done      = done_q;
    assign early     = early_q;

endmodule

// File: doc/state_seq_timer.md
STATE_SEQ_TIMER -- requirements
Module: state_seq_timer

Interface
REQ-001 Parameter N_CH, default 5: number of timed states (channels), 2..16.
REQ-002 Parameter CNT_W, default 22: duration counter width, 8..32.
REQ-003 Parameter CH_W, default 3: channel index width; SHALL satisfy 2**CH_W >= N_CH.
REQ-004 clk_sys  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  N_CH  per-channel start request, level-sampled each cycle.
REQ-007 state_over_in  input  N_CH  per-channel early-termination request.
REQ-008 datain  input  N_CH*CNT_W  packed durations in cycles; channel i at [i*CNT_W +: CNT_W].
REQ-009 abort  input  1  cancel the current state and any pending requests.
REQ-010 clk_en  output  N_CH  one-hot enable for the running channel; all zero otherwise.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 active_ch  output  CH_W  index of the channel being loaded, run or completed.
REQ-013 done  output  1  one-cycle pulse when a state completes.
REQ-014 early  output  1  valid with done; 1 when completion was caused by state_over_in.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, RUN and DONE, all registered.
REQ-016 In IDLE, any nonzero request vector SHALL select the lowest-index set bit into active_ch and go to LOAD the next cycle.
REQ-017 In LOAD, the counter SHALL load datain[active_ch]; the next state is RUN if the value is nonzero, DONE if it is zero.
REQ-018 datain SHALL be sampled only in LOAD; changes during RUN have no effect.
REQ-019 In RUN, clk_en[active_ch] SHALL be 1 and the counter SHALL decrement each cycle; at count 1 the next state is DONE.
REQ-020 A loaded duration D>0 SHALL give exactly D consecutive cycles of clk_en; D=0 gives none, but done still pulses.
REQ-021 state_over_in[active_ch]=1 in RUN SHALL force DONE the next cycle with early=1.
REQ-022 state_over_in bits of non-active channels SHALL be ignored.
REQ-023 In DONE, done SHALL be 1 for one cycle and active_ch SHALL hold the completed channel.
REQ-024 From DONE, the FSM goes to LOAD if a request is available (REQ-031); otherwise it goes to IDLE.
REQ-025 Priority SHALL be abort > state_over_in > counter expiry.
REQ-026 abort in any state SHALL return the FSM to IDLE the next cycle: clk_en=0, no done pulse, counter cleared.
REQ-027 A time-up and state_over_in in the same cycle SHALL produce a single done with early=1.
REQ-028 clk_en, busy, done and early SHALL all be registered outputs.

Reset
REQ-029 On rst_n low: state IDLE, counter 0, clk_en 0, busy 0, active_ch 0, done 0, early 0, pending register 0.
REQ-030 Reset asserted mid-RUN SHALL drop clk_en asynchronously; no done pulse occurs.

Configuration
REQ-031 With macro STATE_SEQ_TIMER_PEND_EN defined:
- start bits seen outside IDLE are OR-ed into an N_CH-bit pending register.
- In IDLE and DONE, selection uses start|pending; the selected pending bit clears on entry to LOAD.
- abort clears the pending register.
Without the macro:
- no pending register exists.
- start is honoured only in IDLE; from DONE the FSM always goes to IDLE.

Verification
REQ-032 Single run: datain[2]=5, start=5'b00100 for one cycle -> busy next cycle; clk_en=5'b00100 for exactly 5 cycles; done=1, early=0, active_ch=2.
REQ-033 Arbitration: start=5'b10010 in IDLE -> channel 1 runs first; with the macro, channel 4 runs immediately after DONE; without it, channel 4 never runs.
REQ-034 Early end: datain[0]=100, state_over_in[0]=1 at RUN cycle 10 -> clk_en low after 10 cycles, done=1, early=1; state_over_in[3] alone has no effect.
REQ-035 Zero duration: datain[1]=0, start[1] pulse -> clk_en stays 0; done pulses 2 cycles after the start sample.
REQ-036 Abort/reset: abort at RUN cycle 3 of a 20-cycle state -> IDLE, no done, pending 0; rst_n low mid-RUN -> all outputs 0 immediately.
REQ-037 Width: CNT_W=22, datain=22'h3FFFFF -> exactly 4194303 clk_en cycles with no wrap.
